// File: rtl/truth_table_capture.sv
// ---------------------------------------------------------------------------
// truth_table_capture
//
// Sequential capture engine for small combinational function blocks (FUTs).
// The engine sweeps every input code through the FUT, samples its single-bit
// output after a programmable settle time, and builds the full truth table.
// It then compares the table against an expected minterm mask and streams the
// indices of all set minterms, in ascending order, over a valid/ready
// handshake.
//
// Parameters
//   N_IN    number of FUT inputs; the truth table is 2**N_IN bits wide
//   SETTLE  cycles o_stim is held before i_y is sampled (1..15)
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   i_start     begin a capture; honoured only while idle
//   i_exp_mask  expected truth table (bit i = FUT output for code i),
//               latched on an accepted start
//   o_stim      input code driven to the FUT (MSB = FUT input A)
//   i_y         FUT output, combinational function of o_stim
//   o_busy      high whenever a capture is in progress
//   o_done      one-cycle pulse at the end of a capture
//   o_table     captured truth table, held until the next start
//   o_match     o_table equals the latched mask; valid from o_done on
//   o_m_valid   minterm index valid
//   i_m_ready   consumer accepts the index
//   o_m_index   current minterm index
//   o_m_last    no higher set minterm remains after this one
// ---------------------------------------------------------------------------
module truth_table_capture #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [(1<<N_IN)-1:0]   i_exp_mask,
  output logic [N_IN-1:0]        o_stim,
  input  logic                   i_y,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [(1<<N_IN)-1:0]   o_table,
  output logic                   o_match,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [N_IN-1:0]        o_m_index,
  output logic                   o_m_last
);

  localparam int TW = 1 << N_IN;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] CODE_MAX    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE     = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   SHAMT_ONE   = {{N_IN{1'b0}}, 1'b1};

  // Architectural state
  logic [2:0]      r_state;
  logic [N_IN-1:0] r_stim;
  logic [3:0]      r_settle_cnt;
  logic [TW-1:0]   r_table;
  logic [TW-1:0]   r_exp_mask;
  logic [N_IN-1:0] r_scan_idx;
  logic            r_match;
  logic            r_done;
  logic            r_busy;
  logic            r_m_valid;
  logic [N_IN-1:0] r_m_index;
  logic            r_m_last;

  // Next-state values
  logic [2:0]      w_state_nxt;
  logic [N_IN-1:0] w_stim_nxt;
  logic [3:0]      w_settle_nxt;
  logic [TW-1:0]   w_table_nxt;
  logic [TW-1:0]   w_exp_nxt;
  logic [N_IN-1:0] w_scan_nxt;
  logic            w_match_nxt;
  logic            w_done_nxt;
  logic            w_step_done;

  // Next values of the stream and status outputs
  logic            w_busy_nxt;
  logic            w_m_valid_nxt;
  logic [N_IN-1:0] w_m_index_nxt;
  logic            w_m_last_nxt;
  logic [N_IN:0]   w_shamt;
  logic [TW-1:0]   w_above;

  // Sequencer: sweep the codes, then scan the captured table
  always_comb begin
    w_state_nxt  = r_state;
    w_stim_nxt   = r_stim;
    w_settle_nxt = r_settle_cnt;
    w_table_nxt  = r_table;
    w_exp_nxt    = r_exp_mask;
    w_scan_nxt   = r_scan_idx;
    w_match_nxt  = r_match;
    w_done_nxt   = 1'b0;
    w_step_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_exp_nxt    = i_exp_mask;
          w_table_nxt  = {TW{1'b0}};
          w_match_nxt  = 1'b0;
          w_stim_nxt   = {N_IN{1'b0}};
          w_settle_nxt = 4'd0;
          w_state_nxt  = S_APPLY;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end

      S_APPLY: begin
        w_settle_nxt = r_settle_cnt + 4'd1;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_state_nxt = S_APPLY;
        end
      end

      S_SAMPLE: begin
        w_table_nxt[r_stim] = i_y;
        // The last code leaves stim parked at all-ones until the next start.
        if (r_stim == CODE_MAX) begin
          w_scan_nxt  = {N_IN{1'b0}};
          w_state_nxt = S_SCAN;
        end else begin
          w_stim_nxt   = r_stim + IDX_ONE;
          w_settle_nxt = 4'd0;
          w_state_nxt  = S_APPLY;
        end
      end

      S_SCAN: begin
        // r_m_valid mirrors r_table[r_scan_idx]; a clear bit never waits.
        w_step_done = ~r_m_valid | i_m_ready;
        if (w_step_done) begin
          if (r_scan_idx == CODE_MAX) begin
            w_state_nxt = S_FIN;
          end else begin
            w_scan_nxt  = r_scan_idx + IDX_ONE;
            w_state_nxt = S_SCAN;
          end
        end else begin
          w_state_nxt = S_SCAN;
        end
      end

      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_match_nxt = (r_table == r_exp_mask);
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values computed from next state so every output is a flop
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_SCAN) begin
      w_m_valid_nxt = w_table_nxt[w_scan_nxt];
      w_m_index_nxt = w_scan_nxt;
    end else begin
      w_m_valid_nxt = 1'b0;
      w_m_index_nxt = {N_IN{1'b0}};
    end
    // One extra bit so the shift past the top index yields an empty table.
    w_shamt      = {1'b0, w_scan_nxt} + SHAMT_ONE;
    w_above      = w_table_nxt >> w_shamt;
    w_m_last_nxt = w_m_valid_nxt & (w_above == {TW{1'b0}});
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_stim       <= {N_IN{1'b0}};
      r_settle_cnt <= 4'd0;
      r_table      <= {TW{1'b0}};
      r_exp_mask   <= {TW{1'b0}};
      r_scan_idx   <= {N_IN{1'b0}};
      r_match      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_index    <= {N_IN{1'b0}};
      r_m_last     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_stim       <= w_stim_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_table      <= w_table_nxt;
      r_exp_mask   <= w_exp_nxt;
      r_scan_idx   <= w_scan_nxt;
      r_match      <= w_match_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= w_busy_nxt;
      r_m_valid    <= w_m_valid_nxt;
      r_m_index    <= w_m_index_nxt;
      r_m_last     <= w_m_last_nxt;
    end
  end

  assign o_stim    = r_stim;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_table   = r_table;
  assign o_match   = r_match;
  assign o_m_valid = r_m_valid;
  assign o_m_index = r_m_index;
  assign o_m_last  = r_m_last;

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequential reader for the team's combinational function blocks, such as 4-input sum-of-products modules.
- Drives the stimulus vector into an external combinational function under test (FUT) and samples its single-bit output for every input code.
- Assembles the full truth table, compares it against an expected minterm mask, and streams the set minterm indices out over a valid/ready handshake.
- Replaces the free-running, self-stopping stimulus benches with a synthesizable, repeatable capture engine.

Parameters:
- N_IN, 4, number of FUT inputs; the table is 2**N_IN bits wide.
- SETTLE, 1, cycles stim is held before y is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a capture; honoured only in IDLE
- exp_mask  input  2**N_IN  expected truth table, bit i = FUT output for input code i; sampled at start
- stim  output  N_IN  input code driven to the FUT (MSB = FUT input A)
- y  input  1  FUT output; combinational function of stim
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of capture
- table  output  2**N_IN  captured truth table; held until the next start
- match  output  1  table == captured exp_mask; valid from done until the next start
- m_valid  output  1  minterm index valid
- m_ready  input  1  consumer accepts the index
- m_index  output  N_IN  current minterm index
- m_last  output  1  qualifies m_valid; no higher set bit remains

Behaviour:
- Reset: all outputs and internal registers go to 0, and the FSM enters IDLE. This applies from any state, including mid-sweep and mid-stream. Nothing is emitted after a reset.
- States: IDLE, APPLY, SAMPLE, SCAN, FIN.
- IDLE:
  - start=1 latches exp_mask, clears table and match, sets stim=0 and settle_cnt=0, then goes to APPLY.
  - start while busy is ignored.
- APPLY:
  - stim is held.
  - settle_cnt increments each cycle. When settle_cnt==SETTLE-1, go to SAMPLE.
- SAMPLE:
  - table[stim] <= y.
  - If stim == 2**N_IN-1, go to SCAN with scan_idx=0.
  - Otherwise stim increments by 1, settle_cnt=0, and the FSM returns to APPLY.
  - Each code costs SETTLE+1 cycles, so the sweep takes 2**N_IN*(SETTLE+1) cycles; this is 32 for the defaults.
  - stim never wraps during a sweep. At sweep end it stays at 2**N_IN-1 until the next start.
- SCAN, one index per step:
  - If table[scan_idx]=1: m_valid=1 and m_index=scan_idx. The step completes only on m_valid && m_ready; m_index is stable while stalled.
  - If table[scan_idx]=0: m_valid=0 and the step completes in 1 cycle.
  - On completion of the step at scan_idx == 2**N_IN-1, go to FIN. Otherwise scan_idx increments.
  - With m_ready held high the scan takes exactly 2**N_IN cycles.
- m_last: m_valid && (table >> (scan_idx+1)) == 0.
- m_valid, m_index and m_last are registered or derived from registered state only. m_valid never depends combinationally on m_ready.
- All-zero table: m_valid is never asserted, and the FSM still walks SCAN to FIN.
- FIN:
  - done=1 for exactly one cycle; match is registered in this cycle.
  - Then go to IDLE, with busy dropping the following cycle.
  - A start in that following IDLE cycle begins a new capture back-to-back.
- busy=1 in APPLY, SAMPLE, SCAN and FIN.

Test Plan:
- Reset value check: hold rst for 2 cycles -> all outputs 0 and busy=0. While idle, change exp_mask with no start -> no output change.
- Sweep and stream: FUT y = ~A&B | A&~B&C&D | A&B&~C, exp_mask=16'h38F0, m_ready=1, start pulse.
  - table=16'h38F0 and match=1.
  - m_index sequence 4,5,6,7,11,12,13, with m_last only on 13.
  - done exactly 32+16+1 cycles after the start edge.
- Mismatch: same FUT with exp_mask=16'h38F1 -> table=16'h38F0, match=0 at done.
- Backpressure: m_ready toggles 0,0,1 repeatedly -> each index is held stable for 3 cycles. Sequence unchanged, no index lost or duplicated.
- Boundary tables:
  - FUT y=0 -> no m_valid, table=16'h0000, done still pulses.
  - FUT y=1 -> indices 0..15, m_last only on 15.
  - SETTLE=3 -> sweep takes 64 cycles.
- Reset mid-operation and start while busy:
  - Assert rst at stim=9 during the sweep -> next cycle busy=0, table=0, m_valid=0. A new start completes normally.
  - Pulse start during SCAN -> ignored, stream continues unchanged.
